// File: rtl/tgt_ddr_pkg.sv
// Shared definitions for the target HDR-DDR path: transmitter mode codes
// (common to tx_t and the DDR CCC engine) and the read sequencer state encoding.
package tgt_ddr_pkg;

    localparam logic [2:0] MODE_PREAMBLE_ZERO   = 3'b000;
    localparam logic [2:0] MODE_PREAMBLE_ONE    = 3'b001;
    localparam logic [2:0] MODE_CRC_TOKEN       = 3'b010;
    localparam logic [2:0] MODE_SERIALIZING_BYTE = 3'b011;
    localparam logic [2:0] MODE_PAR_VALUE       = 3'b110;
    localparam logic [2:0] MODE_CRC_VALUE       = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE_DATA,
        ST_BYTE_HI,
        ST_BYTE_LO,
        ST_PARITY,
        ST_PRE_CRC,
        ST_TOKEN,
        ST_CRC,
        ST_FINISH
    } seq_state_t;

endpackage

// File: rtl/tgt_ddr_tx_sequencer.sv
// Target HDR-DDR read-data sequencer: walks tx_t through preamble/data/parity
// per word, then preamble/CRC token/CRC value, stepping the reg-file read address.
//
// state    | meaning
// IDLE     | waiting for i_start
// PRE_DATA | data-word preamble (mode 001)
// BYTE_HI  | first data byte of the word (mode 011)
// BYTE_LO  | second data byte of the word (mode 011)
// PARITY   | word parity (mode 110)
// PRE_CRC  | terminating preamble (mode 000)
// TOKEN    | CRC token (mode 010)
// CRC      | CRC value (mode 111)
// FINISH   | one-cycle completion pulse, transmitter released
module tgt_ddr_tx_sequencer
    import tgt_ddr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_word_count,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_abort,
    input  logic              i_tx_mode_done,
    output logic              o_tx_en,
    output logic [2:0]        o_tx_mode,
    output logic              o_regf_rd_en,
    output logic [ADDR_W-1:0] o_regf_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted
);

    seq_state_t       state;
    logic [CNT_W-1:0] wcnt;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state        <= ST_IDLE;
            wcnt         <= '0;
            o_tx_en      <= 1'b0;
            o_tx_mode    <= MODE_PREAMBLE_ZERO;
            o_regf_rd_en <= 1'b0;
            o_regf_addr  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
        end else begin
            o_regf_rd_en <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            // Abort wins over a coincident mode-done; the read address is left as-is.
            if (state != ST_IDLE && i_abort) begin
                state     <= ST_IDLE;
                o_tx_en   <= 1'b0;
                o_tx_mode <= MODE_PREAMBLE_ZERO;
                o_busy    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            wcnt        <= i_word_count;
                            o_regf_addr <= i_base_addr;
                            o_tx_en     <= 1'b1;
                            o_busy      <= 1'b1;
                            if (i_word_count != '0) begin
                                state     <= ST_PRE_DATA;
                                o_tx_mode <= MODE_PREAMBLE_ONE;
                            end else begin
                                state     <= ST_PRE_CRC;
                                o_tx_mode <= MODE_PREAMBLE_ZERO;
                            end
                        end
                    end
                    ST_PRE_DATA: begin
                        if (i_tx_mode_done) begin
                            state        <= ST_BYTE_HI;
                            o_tx_mode    <= MODE_SERIALIZING_BYTE;
                            o_regf_rd_en <= 1'b1;
                        end
                    end
                    ST_BYTE_HI: begin
                        if (i_tx_mode_done) begin
                            state        <= ST_BYTE_LO;
                            o_regf_addr  <= o_regf_addr + 1'b1;
                            o_regf_rd_en <= 1'b1;
                        end
                    end
                    ST_BYTE_LO: begin
                        if (i_tx_mode_done) begin
                            state       <= ST_PARITY;
                            o_regf_addr <= o_regf_addr + 1'b1;
                            o_tx_mode   <= MODE_PAR_VALUE;
                        end
                    end
                    ST_PARITY: begin
                        if (i_tx_mode_done) begin
                            wcnt <= wcnt - 1'b1;
                            if (wcnt != CNT_W'(1)) begin
                                state     <= ST_PRE_DATA;
                                o_tx_mode <= MODE_PREAMBLE_ONE;
                            end else begin
                                state     <= ST_PRE_CRC;
                                o_tx_mode <= MODE_PREAMBLE_ZERO;
                            end
                        end
                    end
                    ST_PRE_CRC: begin
                        if (i_tx_mode_done) begin
                            state     <= ST_TOKEN;
                            o_tx_mode <= MODE_CRC_TOKEN;
                        end
                    end
                    ST_TOKEN: begin
                        if (i_tx_mode_done) begin
                            state     <= ST_CRC;
                            o_tx_mode <= MODE_CRC_VALUE;
                        end
                    end
                    ST_CRC: begin
                        if (i_tx_mode_done) begin
                            state     <= ST_FINISH;
                            o_tx_en   <= 1'b0;
                            o_tx_mode <= MODE_PREAMBLE_ZERO;
                            o_done    <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        o_tx_en   <= 1'b0;
                        o_tx_mode <= MODE_PREAMBLE_ZERO;
                        o_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tgt_ddr_tx_sequencer.sv
// Bench for tgt_ddr_tx_sequencer: phase-list reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized sequences.
module tb_tgt_ddr_tx_sequencer;

    logic       clk = 1'b0;
    logic       i_sys_rst, i_start, i_abort, i_tx_mode_done;
    logic [7:0] i_word_count, i_base_addr;
    logic       o_tx_en, o_regf_rd_en, o_busy, o_done, o_aborted;
    logic [2:0] o_tx_mode;
    logic [7:0] o_regf_addr;

    tgt_ddr_tx_sequencer #(.ADDR_W(8), .CNT_W(8)) dut (
        .i_sys_clk(clk), .i_sys_rst(i_sys_rst), .i_start(i_start),
        .i_word_count(i_word_count), .i_base_addr(i_base_addr), .i_abort(i_abort),
        .i_tx_mode_done(i_tx_mode_done), .o_tx_en(o_tx_en), .o_tx_mode(o_tx_mode),
        .o_regf_rd_en(o_regf_rd_en), .o_regf_addr(o_regf_addr), .o_busy(o_busy),
        .o_done(o_done), .o_aborted(o_aborted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a read response is the phase list
    // wc x {001, 011, 011, 110} followed by {000, 010, 111}.
    function automatic int ph_mode(input int idx, input int wc);
        if (idx < 4 * wc) begin
            case (idx % 4)
                0: return 1;
                1: return 3;
                2: return 3;
                default: return 6;
            endcase
        end
        case (idx - 4 * wc)
            0: return 0;
            1: return 2;
            default: return 7;
        endcase
    endfunction

    function automatic bit ph_byte(input int idx, input int wc);
        return (idx < 4 * wc) && ((idx % 4 == 1) || (idx % 4 == 2));
    endfunction

    bit       m_active = 0, m_fin = 0, m_abort_p = 0, m_first = 0;
    int       m_idx = 0, m_wc = 0, m_age = 0, m_tgt = 0;
    bit [7:0] m_addr = 0;
    int       fixed_dly = 0;
    bit       auto_en = 1;
    bit       chk_en = 0;

    function automatic void new_phase();
        m_first = 1;
        m_age   = 0;
        m_tgt   = (fixed_dly > 0) ? fixed_dly - 1 : int'($urandom_range(0, 5));
    endfunction

    always @(posedge clk) begin
        if (i_sys_rst) begin
            m_active = 0; m_fin = 0; m_abort_p = 0; m_first = 0;
            m_addr = 0; m_idx = 0; m_age = 0;
        end else begin
            m_abort_p = 0;
            if (m_fin) begin
                m_fin = 0;
                if (i_abort) m_abort_p = 1;
            end else if (m_active) begin
                if (i_abort) begin
                    m_active  = 0;
                    m_abort_p = 1;
                end else if (i_tx_mode_done) begin
                    if (ph_byte(m_idx, m_wc)) m_addr = m_addr + 8'd1;
                    m_idx++;
                    new_phase();
                    if (m_idx == 4 * m_wc + 3) begin
                        m_active = 0;
                        m_fin    = 1;
                    end
                end else begin
                    m_first = 0;
                    m_age++;
                end
            end else if (i_start) begin
                m_active = 1;
                m_wc     = int'(i_word_count);
                m_addr   = i_base_addr;
                m_idx    = 0;
                new_phase();
            end
        end
    end

    // Per-cycle compare plus a log of observed modes/read addresses for literal checks.
    int mode_q[$];
    int rd_q[$];
    int done_cnt = 0, abort_cnt = 0;
    bit prev_en = 0, last_done = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_en",   int'(o_tx_en),      int'(m_active));
            chk("tx_mode", int'(o_tx_mode),    m_active ? ph_mode(m_idx, m_wc) : 0);
            chk("rd_en",   int'(o_regf_rd_en), int'(m_active && m_first && ph_byte(m_idx, m_wc)));
            chk("addr",    int'(o_regf_addr),  int'(m_addr));
            chk("busy",    int'(o_busy),       int'(m_active || m_fin));
            chk("done",    int'(o_done),       int'(m_fin));
            chk("aborted", int'(o_aborted),    int'(m_abort_p));
        end
        if (o_tx_en === 1'b1 && (!prev_en || last_done)) mode_q.push_back(int'(o_tx_mode));
        if (o_regf_rd_en === 1'b1) rd_q.push_back(int'(o_regf_addr));
        if (o_done === 1'b1) done_cnt++;
        if (o_aborted === 1'b1) abort_cnt++;
        prev_en   = (o_tx_en === 1'b1);
        last_done = i_tx_mode_done;
    end

    task automatic step(input bit st, input bit ab, input bit fd);
        i_start        = st;
        i_abort        = ab;
        i_tx_mode_done = fd || (auto_en && m_active && m_age >= m_tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int wc, input int base, input bit start_ab,
                           input int abort_pm, input int sbusy_pct, input int rst_pm);
        int cyc = 0;
        i_word_count = 8'(wc);
        i_base_addr  = 8'(base);
        step(1, start_ab, 0);
        while ((m_active || m_fin) && cyc < 20000) begin
            bit st = 0, ab = 0;
            if (m_active && $urandom_range(0, 999) < abort_pm) ab = 1;
            if ($urandom_range(0, 99) < sbusy_pct) begin
                st = 1;
                i_word_count = 8'($urandom);
                i_base_addr  = 8'($urandom);
            end
            if (rst_pm > 0 && $urandom_range(0, 999) < rst_pm) i_sys_rst = 1;
            step(st, ab, 0);
            i_sys_rst = 0;
            cyc++;
        end
        if (cyc >= 20000) chk("seq_timeout", cyc, 0);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    int n0, r0, d0, a0, cyc;
    int exp_m1[7] = '{1, 3, 3, 6, 0, 2, 7};
    int exp_m0[3] = '{0, 2, 7};
    int exp_r3[6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};

    initial begin
        i_sys_rst = 1; i_start = 0; i_abort = 0; i_tx_mode_done = 0;
        i_word_count = 0; i_base_addr = 0;
        step(0, 0, 0);
        chk_en = 1;
        step(0, 0, 0);
        chk("rst_tx_en", int'(o_tx_en), 0);
        chk("rst_mode", int'(o_tx_mode), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_addr", int'(o_regf_addr), 0);
        i_sys_rst = 0;
        step(0, 0, 0);

        // One word, base 0x10, tx_t answers 8 cycles into each mode.
        fixed_dly = 8;
        n0 = mode_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        run_seq(1, 8'h10, 0, 0, 0, 0);
        chk("w1_nmodes", mode_q.size() - n0, 7);
        for (int i = 0; i < 7; i++) chk("w1_mode_seq", (n0 + i < mode_q.size()) ? mode_q[n0 + i] : -1, exp_m1[i]);
        chk("w1_nrd", rd_q.size() - r0, 2);
        chk("w1_rd0", (r0 < rd_q.size()) ? rd_q[r0] : -1, 8'h10);
        chk("w1_rd1", (r0 + 1 < rd_q.size()) ? rd_q[r0 + 1] : -1, 8'h11);
        chk("w1_end_addr", int'(o_regf_addr), 8'h12);
        chk("w1_done_pulses", done_cnt - d0, 1);
        chk("w1_tx_en_after", int'(o_tx_en), 0);

        // Reset while idle.
        i_sys_rst = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("idle_rst_addr", int'(o_regf_addr), 0);
        chk("idle_rst_busy", int'(o_busy), 0);
        i_sys_rst = 0;
        step(0, 0, 0);

        // Zero words: only the CRC word.
        fixed_dly = 3;
        n0 = mode_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        run_seq(0, 8'h55, 0, 0, 0, 0);
        chk("w0_nmodes", mode_q.size() - n0, 3);
        for (int i = 0; i < 3; i++) chk("w0_mode_seq", (n0 + i < mode_q.size()) ? mode_q[n0 + i] : -1, exp_m0[i]);
        chk("w0_nrd", rd_q.size() - r0, 0);
        chk("w0_done_pulses", done_cnt - d0, 1);

        // Three words from 0xFE: read address wraps.
        fixed_dly = 2;
        n0 = mode_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        run_seq(3, 8'hFE, 0, 0, 0, 0);
        chk("w3_nmodes", mode_q.size() - n0, 15);
        chk("w3_nrd", rd_q.size() - r0, 6);
        for (int i = 0; i < 6; i++) chk("w3_rd_wrap", (r0 + i < rd_q.size()) ? rd_q[r0 + i] : -1, exp_r3[i]);
        chk("w3_end_addr", int'(o_regf_addr), 8'h04);

        // Abort coinciding with mode-done in the second word's BYTE_LO.
        fixed_dly = 3;
        r0 = rd_q.size(); d0 = done_cnt; a0 = abort_cnt;
        i_word_count = 8'd2; i_base_addr = 8'h20;
        step(1, 0, 0);
        cyc = 0;
        while (!(m_active && m_idx == 6) && cyc < 200) begin step(0, 0, 0); cyc++; end
        chk("ab_reach_byte_lo", int'(cyc < 200), 1);
        step(0, 1, 1);
        chk("ab_tx_en", int'(o_tx_en), 0);
        chk("ab_mode", int'(o_tx_mode), 0);
        chk("ab_pulse", int'(o_aborted), 1);
        chk("ab_no_done", int'(o_done), 0);
        chk("ab_busy", int'(o_busy), 0);
        chk("ab_addr_hold", int'(o_regf_addr), 8'h23);
        chk("ab_nrd", rd_q.size() - r0, 4);
        step(0, 0, 0);
        chk("ab_pulse_once", int'(o_aborted), 0);
        step(0, 0, 0);
        chk("ab_done_cnt", done_cnt - d0, 0);
        chk("ab_abort_cnt", abort_cnt - a0, 1);

        // Start while busy is ignored.
        fixed_dly = 4;
        n0 = mode_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        i_word_count = 8'd1; i_base_addr = 8'h40;
        step(1, 0, 0);
        cyc = 0;
        while (!(m_active && m_idx == 1) && cyc < 200) begin step(0, 0, 0); cyc++; end
        i_word_count = 8'd5; i_base_addr = 8'h80;
        step(1, 0, 0);
        cyc = 0;
        while ((m_active || m_fin) && cyc < 500) begin step(0, 0, 0); cyc++; end
        chk("sb_timeout", int'(cyc < 500), 1);
        step(0, 0, 0);
        chk("sb_nmodes", mode_q.size() - n0, 7);
        chk("sb_nrd", rd_q.size() - r0, 2);
        chk("sb_rd0", (r0 < rd_q.size()) ? rd_q[r0] : -1, 8'h40);
        chk("sb_done", done_cnt - d0, 1);

        // Full word count.
        fixed_dly = 1;
        r0 = rd_q.size(); d0 = done_cnt;
        run_seq(255, 8'h00, 0, 0, 0, 0);
        chk("full_nrd", rd_q.size() - r0, 510);
        chk("full_end_addr", int'(o_regf_addr), 8'hFE);
        chk("full_done", done_cnt - d0, 1);

        // Randomized sequences with aborts, stray starts, resets and idle mode-done.
        fixed_dly = 0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) step(0, $urandom_range(0, 1) == 1, 1);
            run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 255)),
                    $urandom_range(0, 4) == 0, 20, 5, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
